// File: rtl/program_loader_pkg.sv
// Shared processor definitions: instruction width, store geometry, NOP encoding,
// 4-bit opcodes, and the loader state type.
package processor_defs;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam logic [DATA_W-1:0] NOP_OP = 8'hF0;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_NOT    = 4'h5;
  localparam logic [3:0] OP_LDI    = 4'h6;
  localparam logic [3:0] OP_LD     = 4'h7;
  localparam logic [3:0] OP_ST     = 4'h8;
  localparam logic [3:0] OP_JMP    = 4'h9;
  localparam logic [3:0] OP_JZ     = 4'hA;
  localparam logic [3:0] OP_OUTPUT = 4'hB;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/program_loader_instr_ram.sv
// Instruction store: one synchronous write port, one combinational read port
// so the fetch path sees the same zero-latency timing as the old ROM.
module instr_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset; contents are defined by the loader's clear sweep,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/program_loader.sv
// Operator-facing writer for the instruction store: sweeps it to NOP, accepts keyed
// bytes in LOAD, and hands the combinational fetch port to the processor in RUN.
module program_loader
  import processor_defs::loader_state_e;
  import processor_defs::ST_CLEAR;
  import processor_defs::ST_RUN;
  import processor_defs::ST_LOAD;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 4,
  parameter logic [DATA_W-1:0] NOP_OP = 8'hF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic              wr_pulse,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic              loading
);

  localparam int DEPTH = 2**ADDR_W;

  loader_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              w_full;
  logic              w_we;
  logic [DATA_W-1:0] w_we_data;
  logic [DATA_W-1:0] w_ram_rd;

  assign w_full = (r_count == (ADDR_W+1)'(DEPTH));

  // NOTE: every next-state signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_we           = 1'b0;
    w_we_data      = NOP_OP;

    case (r_state)
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_wr_ptr == '1) begin
          w_state_nxt  = load_en ? ST_LOAD : ST_RUN;
          w_wr_ptr_nxt = '0;
          w_count_nxt  = '0;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end
      end

      ST_RUN: begin
        if (clear_req) begin
          w_state_nxt    = ST_CLEAR;
          w_wr_ptr_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
        end else if (load_en) begin
          w_state_nxt    = ST_LOAD;
          w_wr_ptr_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
        end
      end

      ST_LOAD: begin
        // A clear request outranks a same-cycle commit.
        if (clear_req) begin
          w_state_nxt    = ST_CLEAR;
          w_wr_ptr_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
        end else begin
          if (wr_pulse) begin
            if (w_full) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_we         = 1'b1;
              w_we_data    = wr_data;
              w_wr_ptr_nxt = r_wr_ptr + 1'b1;
              w_count_nxt  = r_count + 1'b1;
            end
          end
          if (!load_en) begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      default: begin
        w_state_nxt  = ST_CLEAR;
        w_wr_ptr_nxt = '0;
        w_count_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_CLEAR;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  instr_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_instr_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_we_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (w_ram_rd)
  );

  // Outside RUN the processor fetches NOPs, so a half-entered program never executes.
  assign rd_data  = (r_state == ST_RUN) ? w_ram_rd : NOP_OP;
  assign wr_ptr   = r_wr_ptr;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign busy     = (r_state == ST_CLEAR);
  assign loading  = (r_state == ST_LOAD);

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader against a mode/array model of the instruction
// store kept at operator level (modes, a byte array, a commit tally).
module tb_program_loader;

  localparam logic [7:0] NOP = 8'hF0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_en;
  logic       wr_pulse;
  logic [7:0] wr_data;
  logic       clear_req;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] wr_ptr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       busy;
  logic       loading;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum int {M_CLEAR, M_RUN, M_LOAD} mode_e;
  mode_e      m_mode;
  logic [7:0] m_mem [16];
  int         m_ptr;
  int         m_cnt;
  bit         m_ovf;

  program_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .wr_pulse  (wr_pulse),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .busy      (busy),
    .loading   (loading)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_rd(input int addr);
    return (m_mode == M_RUN) ? m_mem[addr] : NOP;
  endfunction

  task automatic model_reset();
    m_mode = M_CLEAR;
    m_ptr  = 0;
    m_cnt  = 0;
    m_ovf  = 0;
  endtask

  // Operator-level effect of one clock with the given inputs.
  task automatic model_tick(input bit le, input bit wp, input bit cr, input logic [7:0] wd);
    if (m_mode == M_CLEAR) begin
      m_mem[m_ptr] = NOP;
      if (m_ptr == 15) begin
        m_mode = le ? M_LOAD : M_RUN;
        m_ptr  = 0;
        m_cnt  = 0;
      end else m_ptr = m_ptr + 1;
    end else if (cr) begin
      m_mode = M_CLEAR;
      m_ptr  = 0;
      m_cnt  = 0;
      m_ovf  = 0;
    end else if (m_mode == M_RUN) begin
      if (le) begin
        m_mode = M_LOAD;
        m_ptr  = 0;
        m_cnt  = 0;
        m_ovf  = 0;
      end
    end else begin
      if (wp) begin
        if (m_cnt == 16) m_ovf = 1;
        else begin
          m_mem[m_ptr] = wd;
          m_ptr = (m_ptr + 1) % 16;
          m_cnt = m_cnt + 1;
        end
      end
      if (!le) m_mode = M_RUN;
    end
  endtask

  // Drive one cycle: inputs present before the edge, outputs settled #1 after it.
  task automatic step(input bit le, input bit wp, input bit cr, input logic [7:0] wd);
    load_en   = le;
    wr_pulse  = wp;
    clear_req = cr;
    wr_data   = wd;
    model_tick(le, wp, cr, wd);
    @(posedge clk);
    #1;
    wr_pulse  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    load_en = 0; wr_pulse = 0; clear_req = 0; wr_data = 0; rd_addr = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || loading !== 1'b0 || wr_ptr !== 4'd0 || count !== 5'd0 ||
        full !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: busy=%b loading=%b wr_ptr=%0d count=%0d full=%b ovf=%b, required 1 0 0 0 0 0",
               busy, loading, wr_ptr, count, full, overflow);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_sweep_busy: cycle %0d busy=%b required 1", i, busy);
      end
      step(0, 0, 0, 8'h00);
    end
    n_checks++;
    if (busy !== 1'b0 || loading !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_exit_run: busy=%b loading=%b required 0 0", busy, loading);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== 8'hF0) begin
        n_errors++;
        $display("FAIL reset_ram_nop: addr %0d rd_data=%h required f0", a, rd_data);
      end
    end
  endtask

  task automatic test_load_program();
    logic [7:0] prog [4];
    int         len;
    logic [7:0] b;
    prog = '{8'h90, 8'hA4, 8'h00, 8'h80};
    step(1, 0, 0, 8'h00);
    foreach (prog[i]) step(1, 1, 0, prog[i]);
    n_checks++;
    if (count !== 5'd4 || wr_ptr !== 4'd4 || loading !== 1'b1) begin
      n_errors++;
      $display("FAIL load_four: count=%0d wr_ptr=%0d loading=%b required 4 4 1", count, wr_ptr, loading);
    end
    step(0, 0, 0, 8'h00);
    for (int a = 0; a < 5; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== ((a < 4) ? prog[a] : 8'hF0)) begin
        n_errors++;
        $display("FAIL load_four_read: addr %0d rd_data=%h required %h", a, rd_data,
                 (a < 4) ? prog[a] : 8'hF0);
      end
    end
    // Random-length program with random idle gaps between commits.
    len = $urandom_range(1, 12);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      step(1, 1, 0, b);
      repeat ($urandom_range(0, 2)) step(1, 0, 0, 8'($urandom));
    end
    n_checks++;
    if (count !== 5'(m_cnt) || wr_ptr !== 4'(m_ptr)) begin
      n_errors++;
      $display("FAIL load_rand_count: count=%0d wr_ptr=%0d required %0d %0d", count, wr_ptr, m_cnt, m_ptr);
    end
    step(0, 0, 0, 8'h00);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== exp_rd(a)) begin
        n_errors++;
        $display("FAIL load_rand_read: addr %0d rd_data=%h required %h", a, rd_data, exp_rd(a));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] first;
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (full !== 1'b0) begin
        n_errors++;
        $display("FAIL ovf_full_early: after %0d commits full=%b required 0", i, full);
      end
      step(1, 1, 0, 8'($urandom));
    end
    first = m_mem[0];
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16 || wr_ptr !== 4'd0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_full: full=%b count=%0d wr_ptr=%0d ovf=%b required 1 16 0 0", full, count, wr_ptr, overflow);
    end
    step(1, 1, 0, ~first);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || wr_ptr !== 4'd0) begin
      n_errors++;
      $display("FAIL ovf_sticky: ovf=%b count=%0d wr_ptr=%0d required 1 16 0", overflow, count, wr_ptr);
    end
    step(0, 0, 0, 8'h00);
    rd_addr = 4'd0;
    #1;
    n_checks++;
    if (rd_data !== first || overflow !== 1'b1 || full !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_mem0_held: rd_data=%h ovf=%b full=%b required %h 1 1", rd_data, overflow, full, first);
    end
  endtask

  task automatic test_clear_collision();
    step(1, 0, 0, 8'h00);
    repeat (3) step(1, 1, 0, 8'($urandom));
    step(1, 1, 1, 8'h3C);
    n_checks++;
    if (busy !== 1'b1 || loading !== 1'b0 || wr_ptr !== 4'd0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_wins: busy=%b loading=%b wr_ptr=%0d ovf=%b required 1 0 0 0", busy, loading, wr_ptr, overflow);
    end
    repeat (16) step(0, 0, 0, 8'h00);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_done: busy=%b required 0", busy);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== 8'hF0) begin
        n_errors++;
        $display("FAIL clear_ram_nop: addr %0d rd_data=%h required f0", a, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Mid-CLEAR reset at sweep cycle 7.
    step(0, 0, 1, 8'h00);
    repeat (7) step(0, 0, 0, 8'h00);
    do_reset();
    n_checks++;
    if (busy !== 1'b1 || wr_ptr !== 4'd0 || count !== 5'd0 || loading !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_clear: busy=%b wr_ptr=%0d count=%0d loading=%b required 1 0 0 0", busy, wr_ptr, count, loading);
    end
    reset_n = 1'b1;
    repeat (16) step(1, 0, 0, 8'h00);
    n_checks++;
    if (loading !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_clear_to_load: loading=%b busy=%b required 1 0", loading, busy);
    end
    // Mid-LOAD reset at count 5.
    repeat (5) step(1, 1, 0, 8'($urandom));
    n_checks++;
    if (count !== 5'd5) begin
      n_errors++;
      $display("FAIL reset_mid_load_pre: count=%0d required 5", count);
    end
    do_reset();
    n_checks++;
    if (busy !== 1'b1 || loading !== 1'b0 || wr_ptr !== 4'd0 || count !== 5'd0 ||
        full !== 1'b0 || overflow !== 1'b0 || rd_data !== 8'hF0) begin
      n_errors++;
      $display("FAIL reset_mid_load: busy=%b loading=%b wr_ptr=%0d count=%0d full=%b ovf=%b rd=%h required 1 0 0 0 0 0 f0",
               busy, loading, wr_ptr, count, full, overflow, rd_data);
    end
    reset_n = 1'b1;
    repeat (16) step(0, 0, 0, 8'h00);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== 8'hF0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_discard: addr %0d rd_data=%h busy=%b required f0 0", a, rd_data, busy);
      end
    end
  endtask

  task automatic test_run_and_load_reads();
    logic [4:0] cnt_before;
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h12);
    step(1, 1, 0, 8'h34);
    step(0, 0, 0, 8'h00);
    cnt_before = count;
    step(0, 1, 0, 8'h55);
    n_checks++;
    if (count !== cnt_before || wr_ptr !== 4'd2) begin
      n_errors++;
      $display("FAIL run_ignore_count: count=%0d wr_ptr=%0d required %0d 2", count, wr_ptr, cnt_before);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_data !== exp_rd(a)) begin
        n_errors++;
        $display("FAIL run_ignore_ram: addr %0d rd_data=%h required %h", a, rd_data, exp_rd(a));
      end
    end
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 4'($urandom);
      #1;
      n_checks++;
      if (rd_data !== 8'hF0) begin
        n_errors++;
        $display("FAIL load_forces_nop: addr %0d rd_data=%h required f0", rd_addr, rd_data);
      end
    end
    // Final commit coincides with load_en falling: it must land, then RUN.
    step(0, 1, 0, 8'hC7);
    rd_addr = 4'd0;
    #1;
    n_checks++;
    if (loading !== 1'b0 || count !== 5'd1 || rd_data !== 8'hC7) begin
      n_errors++;
      $display("FAIL fall_commit: loading=%b count=%0d rd=%h required 0 1 c7", loading, count, rd_data);
    end
  endtask

  task automatic test_random();
    bit le, wp, cr;
    for (int i = 0; i < 400; i++) begin
      le = ($urandom_range(0, 3) != 0) ? load_en : ~load_en;
      wp = ($urandom_range(0, 1) == 1);
      cr = ($urandom_range(0, 29) == 0);
      step(le, wp, cr, 8'($urandom));
      rd_addr = 4'($urandom);
      #1;
      n_checks++;
      if (busy !== (m_mode == M_CLEAR) || loading !== (m_mode == M_LOAD) ||
          wr_ptr !== 4'(m_ptr) || count !== 5'(m_cnt) || full !== (m_cnt == 16) ||
          overflow !== m_ovf || rd_data !== exp_rd(int'(rd_addr))) begin
        n_errors++;
        $display("FAIL random_cycle %0d: busy=%b loading=%b wr_ptr=%0d count=%0d full=%b ovf=%b rd=%h required %b %b %0d %0d %b %b %h",
                 i, busy, loading, wr_ptr, count, full, overflow, rd_data,
                 m_mode == M_CLEAR, m_mode == M_LOAD, m_ptr, m_cnt, m_cnt == 16, m_ovf,
                 exp_rd(int'(rd_addr)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_program();
    test_overflow();
    test_clear_collision();
    test_reset_mid();
    test_run_and_load_reads();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
